dcache_2way_ctrl: RTL and testbench



---
 rtl/dcache_2way_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_dcache_2way_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_ctrl.sv
// dcache_2way_ctrl: controller for a 2-way set-associative data cache.
// It sits directly after the tag-compare stage. It serves CPU hits with zero
// latency. On a miss it selects a victim, writes it back if it is dirty,
// refills the line from memory and then replays the access.
// Tag entry layout: bit 24 valid, bit 23 dirty, bits 22:0 tag.
// Optional feature: define DCACHE_PERF_CNT_EN to add the hit/miss counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits; a miss moves to MISS
// MISS      | pick the victim way and latch its tag entry and line
// WRITEBACK | write the dirty victim line to memory and wait for ack
// ALLOCATE  | read the missing line from memory and capture it on ack
// REFILL    | write the fill buffer and new tag into the victim way

module dcache_2way_ctrl #(
    parameter int IDX_W  = 4,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    input  logic              hit_i,
    input  logic [1:0]        hit_way_i,
    input  logic [24:0]       tag1_i,
    input  logic [24:0]       tag2_i,
    input  logic [LINE_W-1:0] data1_i,
    input  logic [LINE_W-1:0] data2_i,
    output logic [1:0]        sram_we_o,
    output logic [24:0]       sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int SETS = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_ALLOCATE,
        S_REFILL
    } state_t;

    state_t            state_q, state_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic              vic_way_q, vic_way_d;
    logic [24:0]       vic_tag_q, vic_tag_d;
    logic [LINE_W-1:0] vic_line_q, vic_line_d;
    logic [LINE_W-1:0] fill_q, fill_d;

    // Address fields; the CPU holds cpu_addr_i stable for the whole miss,
    // so the index and tag are taken straight from it in every state.
    logic [IDX_W-1:0]  idx;
    logic [2:0]        word_sel;
    logic [22:0]       addr_tag;

    assign idx      = cpu_addr_i[5 +: IDX_W];
    assign word_sel = cpu_addr_i[4:2];
    assign addr_tag = cpu_addr_i[31 -: 23];

    // Hit path signals. Only bit 0 of hit_way_i matters once hit_i is set.
    logic              hit_go;
    logic              miss_go;
    logic              hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [24:0]       hit_tag;
    logic [31:0]       hit_word;
    logic [LINE_W-1:0] merged_line;

    assign hit_go   = (state_q == S_IDLE) && cpu_req_i && hit_i;
    assign miss_go  = (state_q == S_IDLE) && cpu_req_i && !hit_i;
    assign hit_way  = hit_way_i[0];
    assign hit_line = hit_way ? data2_i : data1_i;
    assign hit_tag  = hit_way ? tag2_i : tag1_i;
    assign hit_word = hit_line[{word_sel, 5'b0} +: 32];

    // Store merge: the addressed word of the hit line is replaced by the store data.
    always_comb begin
        merged_line = hit_line;
        merged_line[{word_sel, 5'b0} +: 32] = cpu_data_i;
    end

    // Victim choice: an invalid way wins, way0 first; otherwise use the LRU bit.
    logic        vic_sel;
    logic [24:0] vic_entry;

    always_comb begin
        if (!tag1_i[24]) begin
            vic_sel = 1'b0;
        end else if (!tag2_i[24]) begin
            vic_sel = 1'b1;
        end else begin
            vic_sel = lru_q[idx];
        end
        vic_entry = vic_sel ? tag2_i : tag1_i;
    end

    // Next-state logic for the FSM, the LRU bits and the miss-side registers.
    always_comb begin
        state_d    = state_q;
        lru_d      = lru_q;
        vic_way_d  = vic_way_q;
        vic_tag_d  = vic_tag_q;
        vic_line_d = vic_line_q;
        fill_d     = fill_q;
        case (state_q)
            S_IDLE: begin
                if (hit_go) begin
                    lru_d[idx] = ~hit_way;
                end else if (miss_go) begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                vic_way_d  = vic_sel;
                vic_tag_d  = vic_entry;
                vic_line_d = vic_sel ? data2_i : data1_i;
                if (vic_entry[24] && vic_entry[23]) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    fill_d  = mem_data_i;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; a reset mid-miss drops the transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            lru_q      <= '0;
            vic_way_q  <= 1'b0;
            vic_tag_q  <= '0;
            vic_line_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            lru_q      <= lru_d;
            vic_way_q  <= vic_way_d;
            vic_tag_q  <= vic_tag_d;
            vic_line_q <= vic_line_d;
            fill_q     <= fill_d;
        end
    end

    // Output decode. The memory side is a pure function of the registered
    // state, so mem_req_o drops in the cycle after an accepted ack or a reset.
    always_comb begin
        cpu_data_o  = '0;
        cpu_stall_o = 1'b0;
        sram_we_o   = 2'b00;
        sram_tag_o  = '0;
        sram_data_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (state_q)
            S_IDLE: begin
                cpu_stall_o = miss_go;
                if (hit_go) begin
                    if (cpu_we_i) begin
                        sram_we_o[hit_way] = 1'b1;
                        sram_data_o        = merged_line;
                        sram_tag_o         = hit_tag | 25'h0800000;
                    end else begin
                        cpu_data_o = hit_word;
                    end
                end
            end
            S_MISS: begin
                cpu_stall_o = 1'b1;
            end
            S_WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {vic_tag_q[22:0], idx, 5'b0};
                mem_data_o  = vic_line_q;
            end
            S_ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {cpu_addr_i[31:5], 5'b0};
            end
            S_REFILL: begin
                cpu_stall_o          = 1'b1;
                sram_we_o[vic_way_q] = 1'b1;
                sram_tag_o           = {2'b10, addr_tag};
                sram_data_o          = fill_q;
            end
            default: begin
                cpu_stall_o = 1'b1;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Performance counters: replayed hits after a refill count as hits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_go) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_go) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

    // The victim's valid/dirty bits only steer the MISS decision, and the
    // "none" encoding of hit_way_i and the byte offset are never needed.
    logic unused_bits;
    assign unused_bits = ^{vic_tag_q[24:23], hit_way_i[1], cpu_addr_i[1:0]};

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Directed testbench for dcache_2way_ctrl: a table of single-cycle hit vectors
// followed by hand-written miss, write-back, victim-choice and reset sequences.

module tb_dcache_2way_ctrl;

    localparam int IDX_W  = 4;
    localparam int LINE_W = 256;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic              hit_i;
    logic [1:0]        hit_way_i;
    logic [24:0]       tag1_i;
    logic [24:0]       tag2_i;
    logic [LINE_W-1:0] data1_i;
    logic [LINE_W-1:0] data2_i;
    logic [1:0]        sram_we_o;
    logic [24:0]       sram_tag_o;
    logic [LINE_W-1:0] sram_data_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_i;
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;

    always #5 clk_i = ~clk_i;

    dcache_2way_ctrl #(.IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cpu_req_i  (cpu_req_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .hit_i      (hit_i),
        .hit_way_i  (hit_way_i),
        .tag1_i     (tag1_i),
        .tag2_i     (tag2_i),
        .data1_i    (data1_i),
        .data2_i    (data2_i),
        .sram_we_o  (sram_we_o),
        .sram_tag_o (sram_tag_o),
        .sram_data_o(sram_data_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [LINE_W-1:0] mkline(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) begin
            l[i*32 +: 32] = base + 32'(i);
        end
        return l;
    endfunction

    typedef struct {
        logic              req;
        logic              we;
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic              hit;
        logic [1:0]        hway;
        logic [24:0]       t1;
        logic [24:0]       t2;
        logic              chk_rd;
        logic [31:0]       rdata;
        logic [1:0]        swe;
        logic [24:0]       stag;
        logic [LINE_W-1:0] sdata;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    logic [LINE_W-1:0] l0, l1, fill1, fill2;
    logic [31:0]       exp_hits, exp_misses;

    task automatic idle_inputs();
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        hit_i      = 1'b0;
        hit_way_i  = 2'd2;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    endtask

    initial begin
        l0    = mkline(32'hA000_0000);
        l1    = mkline(32'hB000_0000);
        fill1 = mkline(32'hC000_0000);
        fill2 = mkline(32'hD000_0000);

        // req, we, addr, wdata, hit, hway, t1, t2, chk_rd, rdata, swe, stag, sdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 2'd0, 25'h1000ABC, 25'h1000777,
                    1'b1, 32'h0, 2'b00, 25'h0, '0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0028, 32'h0, 1'b1, 2'd0, 25'h1000ABC, 25'h1000777,
                    1'b1, 32'hA000_0002, 2'b00, 25'h0, '0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_005C, 32'h0, 1'b1, 2'd1, 25'h1000ABC, 25'h1000777,
                    1'b1, 32'hB000_0007, 2'b00, 25'h0, '0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_3E6C, 32'hDEAD_BEEF, 1'b1, 2'd1, 25'h1000ABC, 25'h100001F,
                    1'b0, 32'h0, 2'b10, 25'h180001F, l1};
        vecs[3].sdata[3*32 +: 32] = 32'hDEAD_BEEF;
        vecs[4] = '{1'b1, 1'b1, 32'h0000_00A0, 32'h1234_5678, 1'b1, 2'd0, 25'h1000ABC, 25'h1000777,
                    1'b0, 32'h0, 2'b01, 25'h1800ABC, l0};
        vecs[4].sdata[0 +: 32] = 32'h1234_5678;
        vecs[5] = '{1'b1, 1'b1, 32'h0000_00B4, 32'hCAFE_F00D, 1'b1, 2'd0, 25'h1800ABC, 25'h1000777,
                    1'b0, 32'h0, 2'b01, 25'h1800ABC, l0};
        vecs[5].sdata[5*32 +: 32] = 32'hCAFE_F00D;
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0040, 32'h5555_5555, 1'b1, 2'd1, 25'h1000ABC, 25'h1000777,
                    1'b1, 32'h0, 2'b00, 25'h0, '0};

`ifdef DCACHE_PERF_CNT_EN
        exp_hits   = 32'd4;
        exp_misses = 32'd1;
`else
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
`endif

        idle_inputs();
        rst_i      = 1'b1;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        tag1_i     = '0;
        tag2_i     = '0;
        data1_i    = l0;
        data2_i    = l1;
        tick();
        tick();
        rst_i = 1'b0;
        settle();

        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_sram_we", sram_we_o, 2'b00);
        chk("rst_cpu_data", cpu_data_o, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_hit_cnt", hit_cnt_o, 32'h0);
        chk("rst_miss_cnt", miss_cnt_o, 32'h0);
        tick();

        // Single-cycle IDLE vectors: hits, stores and idle requests.
        for (int i = 0; i < NV; i++) begin
            cpu_req_i  = vecs[i].req;
            cpu_we_i   = vecs[i].we;
            cpu_addr_i = vecs[i].addr;
            cpu_data_i = vecs[i].wdata;
            hit_i      = vecs[i].hit;
            hit_way_i  = vecs[i].hway;
            tag1_i     = vecs[i].t1;
            tag2_i     = vecs[i].t2;
            settle();
            chk($sformatf("vec%0d_stall", i), cpu_stall_o, 1'b0);
            chk($sformatf("vec%0d_sram_we", i), sram_we_o, vecs[i].swe);
            chk($sformatf("vec%0d_mem_req", i), mem_req_o, 1'b0);
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d_cpu_data", i), cpu_data_o, vecs[i].rdata);
            end
            if (vecs[i].swe != 2'b00) begin
                chk($sformatf("vec%0d_sram_tag", i), sram_tag_o, vecs[i].stag);
                chk($sformatf("vec%0d_sram_data", i), sram_data_o, vecs[i].sdata);
            end
            tick();
        end
        idle_inputs();

        // Load miss to an invalid set at index 9: no write-back, refill way0, replay.
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0120;
        tag1_i     = '0;
        tag2_i     = '0;
        settle();
        chk("B_idle_stall", cpu_stall_o, 1'b1);
        tick();
        chk("B_miss_stall", cpu_stall_o, 1'b1);
        chk("B_miss_no_req", mem_req_o, 1'b0);
        tick();
        chk("B_alloc_req", mem_req_o, 1'b1);
        chk("B_alloc_we", mem_we_o, 1'b0);
        chk("B_alloc_addr", mem_addr_o, 32'h0000_0120);
        chk("B_alloc_sram_we", sram_we_o, 2'b00);
        tick();
        chk("B_alloc_hold", mem_req_o, 1'b1);
        mem_ack_i  = 1'b1;
        mem_data_i = fill1;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        settle();
        chk("B_refill_req", mem_req_o, 1'b0);
        chk("B_refill_stall", cpu_stall_o, 1'b1);
        chk("B_refill_we", sram_we_o, 2'b01);
        chk("B_refill_tag", sram_tag_o, 25'h1000000);
        chk("B_refill_data", sram_data_o, fill1);
        tick();
        hit_i     = 1'b1;
        hit_way_i = 2'd0;
        tag1_i    = 25'h1000000;
        data1_i   = fill1;
        settle();
        chk("B_replay_stall", cpu_stall_o, 1'b0);
        chk("B_replay_data", cpu_data_o, 32'hC000_0000);
        tick();
        idle_inputs();

        // Both ways valid and clean at index 9: the replay left lru[9]=1, so way1
        // is evicted. The ack arrives in the first ALLOCATE cycle.
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_2120;
        tag1_i     = 25'h1000000;
        tag2_i     = 25'h1000005;
        tick();
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = fill2;
        settle();
        chk("C_alloc_req", mem_req_o, 1'b1);
        chk("C_alloc_we", mem_we_o, 1'b0);
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        settle();
        chk("C_refill_we", sram_we_o, 2'b10);
        chk("C_refill_tag", sram_tag_o, 25'h1000010);
        chk("C_refill_data", sram_data_o, fill2);
        tick();
        idle_inputs();

        // Dirty eviction at index 3 (lru[3]=0 after the store hit to way1).
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_AA60;
        tag1_i     = 25'h1800ABC;
        tag2_i     = 25'h1000777;
        data1_i    = l0;
        data2_i    = l1;
        tick();
        tick();
        data1_i = fill1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                mem_ack_i = 1'b1;
            end
            settle();
            chk($sformatf("D_wb%0d_req", k), mem_req_o, 1'b1);
            chk($sformatf("D_wb%0d_we", k), mem_we_o, 1'b1);
            chk($sformatf("D_wb%0d_addr", k), mem_addr_o, 32'h0015_7860);
            chk($sformatf("D_wb%0d_data", k), mem_data_o, l0);
            tick();
        end
        mem_ack_i = 1'b0;
        settle();
        chk("D_alloc_req", mem_req_o, 1'b1);
        chk("D_alloc_we", mem_we_o, 1'b0);
        chk("D_alloc_addr", mem_addr_o, 32'h0000_AA60);
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = fill2;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        settle();
        chk("D_refill_we", sram_we_o, 2'b01);
        chk("D_refill_tag", sram_tag_o, 25'h1000055);
        chk("D_refill_data", sram_data_o, fill2);
        tick();
        idle_inputs();

        // An invalid way1 is chosen over a valid dirty way0 with lru=0.
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_04E0;
        tag1_i     = 25'h1800001;
        tag2_i     = 25'h0000000;
        tick();
        tick();
        chk("E_alloc_req", mem_req_o, 1'b1);
        chk("E_alloc_we", mem_we_o, 1'b0);
        chk("E_alloc_addr", mem_addr_o, 32'h0000_04E0);
        mem_ack_i  = 1'b1;
        mem_data_i = fill1;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        settle();
        chk("E_refill_we", sram_we_o, 2'b10);
        chk("E_refill_tag", sram_tag_o, 25'h1000002);
        tick();
        idle_inputs();

        // Reset during ALLOCATE at index 9 (lru[9]=1 beforehand).
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_4120;
        tag1_i     = 25'h1000000;
        tag2_i     = 25'h1000010;
        tick();
        tick();
        chk("F_alloc_req", mem_req_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        settle();
        chk("F_rst_mem_req", mem_req_o, 1'b0);
        chk("F_rst_sram_we", sram_we_o, 2'b00);
        chk("F_rst_stall", cpu_stall_o, 1'b0);
        chk("F_rst_hit_cnt", hit_cnt_o, 32'h0);
        chk("F_rst_miss_cnt", miss_cnt_o, 32'h0);
        mem_ack_i  = 1'b1;
        mem_data_i = fill2;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        settle();
        chk("F_late_ack_req", mem_req_o, 1'b0);
        chk("F_late_ack_sram_we", sram_we_o, 2'b00);
        chk("F_late_ack_stall", cpu_stall_o, 1'b0);
        tick();

        // LRU bits were cleared, so the same miss now evicts way0.
        cpu_req_i = 1'b1;
        settle();
        chk("F_miss_stall", cpu_stall_o, 1'b1);
        tick();
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = fill1;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        settle();
        chk("F_refill_we", sram_we_o, 2'b01);
        chk("F_refill_tag", sram_tag_o, 25'h1000020);
        tick();
        hit_i     = 1'b1;
        hit_way_i = 2'd0;
        tag1_i    = 25'h1000020;
        data1_i   = fill1;
        settle();
        chk("F_replay_stall", cpu_stall_o, 1'b0);
        chk("F_replay_data", cpu_data_o, 32'hC000_0000);
        tick();

        // Three more load hits, then read the counters.
        for (int k = 0; k < 3; k++) begin
            cpu_addr_i = 32'h0000_0040 + 32'(k * 4);
            hit_way_i  = 2'd1;
            settle();
            chk($sformatf("G_hit%0d_data", k), cpu_data_o, 32'hB000_0000 + 32'(k));
            tick();
        end
        idle_inputs();
        settle();
        chk("G_hit_cnt", hit_cnt_o, exp_hits);
        chk("G_miss_cnt", miss_cnt_o, exp_misses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
